c1541_track_buf: RTL and testbench

C1541_TRACK_BUF -- requirements
Module: c1541_track_buf

---
 rtl/c1541_track_buf_pkg.sv | 61 ++++++
 rtl/c1541_track_buf_if.sv | 22 ++
 rtl/c1541_track_buf_trkram.sv | 43 ++++
 rtl/c1541_track_buf.sv | 190 +++++++++++++++++++
 tb/tb_c1541_track_buf.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/c1541_track_buf_pkg.sv
// Shared constants, track geometry helpers and FSM state encoding for the
// 1541 track buffer.
package c1541_pkg;

  localparam int NUM_TRACKS  = 35;
  localparam int MAX_SECTORS = 21;
  localparam int TRKBUF_AW   = 13;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FLUSH_REQ  = 3'd1,
    ST_FLUSH_XFER = 3'd2,
    ST_LOAD_REQ   = 3'd3,
    ST_LOAD_XFER  = 3'd4,
    ST_READY      = 3'd5
  } trk_state_e;

  // Track 0 and anything past the last track are treated as "no track".
  function automatic logic trk_valid(input logic [5:0] t);
    return (t >= 6'd1) && (t <= 6'(NUM_TRACKS));
  endfunction

  function automatic logic [4:0] sectors_per_track(input logic [5:0] t);
    logic [4:0] n;
    if (t <= 6'd17)      n = 5'd21;
    else if (t <= 6'd24) n = 5'd19;
    else if (t <= 6'd30) n = 5'd18;
    else                 n = 5'd17;
    return n;
  endfunction

  // First 256-byte block of a track inside the D64 image (10-bit result).
  function automatic logic [9:0] track_lba(input logic [5:0] t);
    logic [9:0] tw;
    logic [9:0] r;
    tw = {4'd0, t};
    if (tw <= 10'd17)      r = 10'd21 * (tw - 10'd1);
    else if (tw <= 10'd24) r = 10'd357 + 10'd19 * (tw - 10'd18);
    else if (tw <= 10'd30) r = 10'd490 + 10'd18 * (tw - 10'd25);
    else                   r = 10'd598 + 10'd17 * (tw - 10'd31);
    return r;
  endfunction

  function automatic logic [31:0] blk_lba(input logic [5:0] t, input logic [4:0] s);
    logic [9:0] v;
    v = track_lba(t) + {5'd0, s};
    return {22'd0, v};
  endfunction

  // Lowest set bit of the dirty vector; 0 when the vector is empty.
  function automatic logic [4:0] first_dirty(input logic [20:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 20; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
      else      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/c1541_track_buf_if.sv
// SD host block-transfer bus: the track buffer requests blocks, the host
// acknowledges and streams bytes.
interface c1541_track_buf_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/c1541_track_buf_trkram.sv
// True dual-port 5376x8 track RAM with registered reads.
// Port A: GCR stage, port B: SD host. Port B wins a same-address write race.
module c1541_trkram
  import c1541_pkg::*;
(
  input  logic                 clk32,
  input  logic                 rst_n,
  input  logic [TRKBUF_AW-1:0] addr_a,
  input  logic [7:0]           din_a,
  input  logic                 we_a,
  output logic [7:0]           dout_a,
  input  logic [TRKBUF_AW-1:0] addr_b,
  input  logic [7:0]           din_b,
  input  logic                 we_b,
  output logic [7:0]           dout_b
);
  localparam int DEPTH = MAX_SECTORS * 256;

  logic [7:0] mem_r [0:DEPTH-1];
  logic       in_a_s;
  logic       in_b_s;

  // Sector numbers above 20 address past the end of the array.
  assign in_a_s = (addr_a < 13'(DEPTH));
  assign in_b_s = (addr_b < 13'(DEPTH));

  // Storage writes from both ports.
  always_ff @(posedge clk32) begin
    if (we_a && in_a_s) mem_r[addr_a] <= din_a;
    if (we_b && in_b_s) mem_r[addr_b] <= din_b;
  end

  // Registered read data for both ports, cleared by reset.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      dout_a <= 8'd0;
      dout_b <= 8'd0;
    end else begin
      dout_a <= in_a_s ? mem_r[addr_a] : 8'd0;
      dout_b <= in_b_s ? mem_r[addr_b] : 8'd0;
    end
  end
endmodule

// File: rtl/c1541_track_buf.sv
// Whole-track cache between the GCR stage and the SD host: loads the
// requested track sector by sector and writes dirty sectors back first.
module c1541_track_buf
  import c1541_pkg::*;
(
  input  logic              clk32,
  input  logic              rst_n,
  input  logic [5:0]        track,
  input  logic              img_mounted,
  input  logic              img_readonly,
  c1541_track_buf_if.master sd,
  input  logic [4:0]        sector,
  input  logic [7:0]        byte_addr,
  output logic [7:0]        ram_do,
  input  logic [7:0]        ram_di,
  input  logic              ram_we,
  output logic              ram_ready,
  output logic              busy
);
  localparam logic [2:0] IDLE       = ST_IDLE;
  localparam logic [2:0] FLUSH_REQ  = ST_FLUSH_REQ;
  localparam logic [2:0] FLUSH_XFER = ST_FLUSH_XFER;
  localparam logic [2:0] LOAD_REQ   = ST_LOAD_REQ;
  localparam logic [2:0] LOAD_XFER  = ST_LOAD_XFER;
  localparam logic [2:0] READY      = ST_READY;

  logic [2:0]  state_r;
  logic [5:0]  loaded_trk_r;
  logic [5:0]  target_r;
  logic [4:0]  cur_sec_r;
  logic [4:0]  flush_sec_r;
  logic [20:0] dirty_r;
  logic        mount_pend_r;
  logic        ack_d_r;
  logic [31:0] sd_lba_r;
  logic        sd_rd_r;
  logic        sd_wr_r;

  logic        ram_ready_s;
  logic        ram_wr_s;
  logic        host_wr_s;
  logic        ack_fall_s;
  logic [20:0] dirty_rem_s;
  logic [4:0]  sec_b_s;
  logic [7:0]  buf_din_s;

  // Combinational on track so a write issued with a track change is dropped.
  assign ram_ready_s = (state_r == READY) && (track == loaded_trk_r) && trk_valid(loaded_trk_r);
  assign ram_wr_s    = ram_we && ram_ready_s;
  assign host_wr_s   = sd.sd_buff_wr && (state_r == LOAD_XFER);
  assign ack_fall_s  = ack_d_r && !sd.sd_ack;
  assign dirty_rem_s = dirty_r & ~(21'd1 << flush_sec_r);

  // Host port addresses the sector being flushed or the sector being loaded.
  always_comb begin
    sec_b_s = cur_sec_r;
    if ((state_r == FLUSH_REQ) || (state_r == FLUSH_XFER)) sec_b_s = flush_sec_r;
    else                                                     sec_b_s = cur_sec_r;
  end

  c1541_trkram u_ram (
    .clk32  (clk32),
    .rst_n  (rst_n),
    .addr_a ({sector, byte_addr}),
    .din_a  (ram_di),
    .we_a   (ram_wr_s),
    .dout_a (ram_do),
    .addr_b ({sec_b_s, sd.sd_buff_addr}),
    .din_b  (sd.sd_buff_dout),
    .we_b   (host_wr_s),
    .dout_b (buf_din_s)
  );

  assign sd.sd_lba      = sd_lba_r;
  assign sd.sd_rd       = sd_rd_r;
  assign sd.sd_wr       = sd_wr_r;
  assign sd.sd_buff_din = buf_din_s;
  assign ram_ready      = ram_ready_s;
  assign busy           = sd_rd_r || sd_wr_r || (state_r == FLUSH_XFER) || (state_r == LOAD_XFER);

  // Track-change sequencing: flush dirty sectors, then load the new track.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      loaded_trk_r <= 6'd0;
      target_r     <= 6'd0;
      cur_sec_r    <= 5'd0;
      flush_sec_r  <= 5'd0;
      dirty_r      <= 21'd0;
      mount_pend_r <= 1'b0;
      ack_d_r      <= 1'b0;
      sd_lba_r     <= 32'd0;
      sd_rd_r      <= 1'b0;
      sd_wr_r      <= 1'b0;
    end else begin
      ack_d_r <= sd.sd_ack;
      if (img_mounted) mount_pend_r <= 1'b1;
      if (ram_wr_s && (sector < 5'(MAX_SECTORS))) dirty_r[sector] <= 1'b1;

      case (state_r)
        IDLE, READY: begin
          if (mount_pend_r) begin
            // New image: old dirty data belongs to the previous image.
            dirty_r      <= 21'd0;
            loaded_trk_r <= 6'd0;
            mount_pend_r <= img_mounted;
            state_r      <= IDLE;
          end else if (track != loaded_trk_r) begin
            if ((dirty_r != 21'd0) && !img_readonly) begin
              flush_sec_r <= first_dirty(dirty_r);
              sd_lba_r    <= blk_lba(loaded_trk_r, first_dirty(dirty_r));
              sd_wr_r     <= 1'b1;
              state_r     <= FLUSH_REQ;
            end else if (trk_valid(track)) begin
              target_r     <= track;
              cur_sec_r    <= 5'd0;
              dirty_r      <= 21'd0;
              loaded_trk_r <= 6'd0;
              sd_lba_r     <= blk_lba(track, 5'd0);
              sd_rd_r      <= 1'b1;
              state_r      <= LOAD_REQ;
            end else begin
              dirty_r      <= 21'd0;
              loaded_trk_r <= 6'd0;
              state_r      <= IDLE;
            end
          end else if (trk_valid(loaded_trk_r)) begin
            state_r <= READY;
          end else begin
            state_r <= IDLE;
          end
        end
        FLUSH_REQ: begin
          if (sd.sd_ack) begin
            sd_wr_r <= 1'b0;
            state_r <= FLUSH_XFER;
          end else begin
            state_r <= FLUSH_REQ;
          end
        end
        FLUSH_XFER: begin
          if (ack_fall_s) begin
            dirty_r <= dirty_rem_s;
            if (!mount_pend_r && (dirty_rem_s != 21'd0)) begin
              flush_sec_r <= first_dirty(dirty_rem_s);
              sd_lba_r    <= blk_lba(loaded_trk_r, first_dirty(dirty_rem_s));
              sd_wr_r     <= 1'b1;
              state_r     <= FLUSH_REQ;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= FLUSH_XFER;
          end
        end
        LOAD_REQ: begin
          if (sd.sd_ack) begin
            sd_rd_r <= 1'b0;
            state_r <= LOAD_XFER;
          end else begin
            state_r <= LOAD_REQ;
          end
        end
        LOAD_XFER: begin
          if (ack_fall_s) begin
            if (mount_pend_r || (track != target_r)) begin
              // Abandon this track; IDLE restarts from sector 0 of the new one.
              state_r <= IDLE;
            end else if (cur_sec_r == (sectors_per_track(target_r) - 5'd1)) begin
              loaded_trk_r <= target_r;
              state_r      <= READY;
            end else begin
              cur_sec_r <= cur_sec_r + 5'd1;
              sd_lba_r  <= blk_lba(target_r, cur_sec_r + 5'd1);
              sd_rd_r   <= 1'b1;
              state_r   <= LOAD_REQ;
            end
          end else begin
            state_r <= LOAD_XFER;
          end
        end
        default: begin
          sd_rd_r <= 1'b0;
          sd_wr_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_c1541_track_buf.sv
// Directed bench for c1541_track_buf with a simple SD host model.
module tb_c1541_track_buf;
  logic       clk32 = 1'b0;
  logic       rst_n;
  logic [5:0] track;
  logic       img_mounted;
  logic       img_readonly;
  logic [4:0] sector;
  logic [7:0] byte_addr;
  logic [7:0] ram_do;
  logic [7:0] ram_di;
  logic       ram_we;
  logic       ram_ready;
  logic       busy;

  int n_vec;
  int n_err;

  c1541_track_buf_if sd ();

  c1541_track_buf dut (
    .clk32        (clk32),
    .rst_n        (rst_n),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .sd           (sd),
    .sector       (sector),
    .byte_addr    (byte_addr),
    .ram_do       (ram_do),
    .ram_di       (ram_di),
    .ram_we       (ram_we),
    .ram_ready    (ram_ready),
    .busy         (busy)
  );

  always #5 clk32 = ~clk32;

  // Byte the host model delivers for block lba, offset i.
  function automatic logic [7:0] pat(input logic [31:0] lba, input logic [7:0] i);
    logic [7:0] l;
    l = lba[7:0];
    return (l * 8'd29 + 8'd11) ^ i;
  endfunction

  // Track 1 buffer contents after the three GCR-side writes below.
  function automatic logic [7:0] exp_flush(input logic [4:0] s, input logic [7:0] a);
    if (s == 5'd3 && a == 8'h10)      return 8'hC3;
    else if (s == 5'd3 && a == 8'h80) return 8'h3C;
    else if (s == 5'd7 && a == 8'h00) return 8'h77;
    else                              return pat({27'd0, s}, a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk32); #1;
      if (sd.sd_rd || sd.sd_wr) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve_read(input logic [31:0] exp_lba, input logic [5:0] chg_trk);
    bit got;
    wait_req(got);
    chk("rd_req", {31'd0, sd.sd_rd}, 32'd1);
    chk("rd_no_wr", {31'd0, sd.sd_wr}, 32'd0);
    chk("rd_lba", sd.sd_lba, exp_lba);
    if (got) begin
      sd.sd_ack = 1'b1;
      @(posedge clk32); #1;
      chk("rd_drop", {31'd0, sd.sd_rd}, 32'd0);
      chk("busy_xfer", {31'd0, busy}, 32'd1);
      if (chg_trk != 6'd0) track = chg_trk;
      for (int i = 0; i < 256; i++) begin
        sd.sd_buff_addr = 8'(i);
        sd.sd_buff_dout = pat(exp_lba, 8'(i));
        sd.sd_buff_wr   = 1'b1;
        @(posedge clk32); #1;
      end
      sd.sd_buff_wr = 1'b0;
      sd.sd_ack     = 1'b0;
      @(posedge clk32); #1;
    end
  endtask

  task automatic serve_write(input logic [31:0] exp_lba, input logic [4:0] s);
    bit got;
    logic [7:0] a;
    wait_req(got);
    chk("wr_req", {31'd0, sd.sd_wr}, 32'd1);
    chk("wr_no_rd", {31'd0, sd.sd_rd}, 32'd0);
    chk("wr_lba", sd.sd_lba, exp_lba);
    if (got) begin
      sd.sd_ack = 1'b1;
      @(posedge clk32); #1;
      chk("wr_drop", {31'd0, sd.sd_wr}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        case (k)
          0:       a = 8'h00;
          1:       a = 8'h10;
          2:       a = 8'h80;
          default: a = 8'hFF;
        endcase
        sd.sd_buff_addr = a;
        @(posedge clk32); #1;
        chk("flush_din", {24'd0, sd.sd_buff_din}, {24'd0, exp_flush(s, a)});
      end
      sd.sd_ack = 1'b0;
      @(posedge clk32); #1;
    end
  endtask

  task automatic buf_write(input logic [4:0] s, input logic [7:0] a, input logic [7:0] d);
    sector    = s;
    byte_addr = a;
    ram_di    = d;
    ram_we    = 1'b1;
    @(posedge clk32); #1;
    ram_we = 1'b0;
  endtask

  task automatic load_track(input int base, input int n);
    for (int s = 0; s < n; s++) serve_read(32'(base + s), 6'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    track = 6'd0;
    img_mounted = 1'b0;
    img_readonly = 1'b0;
    sector = 5'd0;
    byte_addr = 8'd0;
    ram_di = 8'd0;
    ram_we = 1'b0;
    sd.sd_ack = 1'b0;
    sd.sd_buff_addr = 8'd0;
    sd.sd_buff_dout = 8'd0;
    sd.sd_buff_wr = 1'b0;

    // Reset values
    repeat (3) @(posedge clk32);
    #1;
    chk("rst_sd_rd", {31'd0, sd.sd_rd}, 32'd0);
    chk("rst_sd_wr", {31'd0, sd.sd_wr}, 32'd0);
    chk("rst_sd_lba", sd.sd_lba, 32'd0);
    chk("rst_buff_din", {24'd0, sd.sd_buff_din}, 32'd0);
    chk("rst_ram_do", {24'd0, ram_do}, 32'd0);
    chk("rst_ram_ready", {31'd0, ram_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk32);
    #1;
    chk("idle_trk0_rd", {31'd0, sd.sd_rd}, 32'd0);
    chk("idle_trk0_busy", {31'd0, busy}, 32'd0);

    // Track 1: LBA 0..20, then a read of sector 20 byte 0xFF
    track = 6'd1;
    load_track(0, 21);
    chk("t1_ready", {31'd0, ram_ready}, 32'd1);
    chk("t1_not_busy", {31'd0, busy}, 32'd0);
    sector = 5'd20;
    byte_addr = 8'hFF;
    @(posedge clk32); #1;
    chk("t1_s20_ff", {24'd0, ram_do}, {24'd0, pat(32'd20, 8'hFF)});

    // Zone boundaries: tracks 18 and 35
    track = 6'd18;
    load_track(357, 19);
    chk("t18_ready", {31'd0, ram_ready}, 32'd1);
    track = 6'd35;
    load_track(666, 17);
    chk("t35_ready", {31'd0, ram_ready}, 32'd1);

    // Out-of-range track: no transfer, not ready
    track = 6'd36;
    #1;
    chk("t36_ready_now", {31'd0, ram_ready}, 32'd0);
    repeat (10) @(posedge clk32);
    #1;
    chk("t36_no_rd", {31'd0, sd.sd_rd}, 32'd0);
    chk("t36_no_wr", {31'd0, sd.sd_wr}, 32'd0);
    chk("t36_ready", {31'd0, ram_ready}, 32'd0);

    // Dirty sectors 3 and 7 flushed before loading track 2
    track = 6'd1;
    load_track(0, 21);
    chk("t1b_ready", {31'd0, ram_ready}, 32'd1);
    buf_write(5'd3, 8'h10, 8'hC3);
    buf_write(5'd3, 8'h80, 8'h3C);
    buf_write(5'd7, 8'h00, 8'h77);
    sector = 5'd3;
    byte_addr = 8'h10;
    @(posedge clk32); #1;
    chk("gcr_readback", {24'd0, ram_do}, 32'h0000_00C3);
    track = 6'd2;
    serve_write(32'd3, 5'd3);
    serve_write(32'd7, 5'd7);
    load_track(21, 21);
    chk("t2_ready", {31'd0, ram_ready}, 32'd1);

    // Read-only image: dirty data discarded, track 3 loaded directly
    buf_write(5'd3, 8'h00, 8'h55);
    img_readonly = 1'b1;
    track = 6'd3;
    load_track(42, 21);
    chk("t3_ro_ready", {31'd0, ram_ready}, 32'd1);
    img_readonly = 1'b0;

    // Write coincident with track change is dropped; track 1->25 mid-load
    sector = 5'd4;
    byte_addr = 8'h00;
    ram_di = 8'hAA;
    ram_we = 1'b1;
    track = 6'd1;
    @(posedge clk32); #1;
    ram_we = 1'b0;
    load_track(0, 5);
    serve_read(32'd5, 6'd25);
    load_track(490, 18);
    chk("t25_ready", {31'd0, ram_ready}, 32'd1);

    // Image change: dirty bits cleared without flush, track reloaded
    track = 6'd1;
    load_track(0, 21);
    buf_write(5'd3, 8'h10, 8'hC3);
    buf_write(5'd7, 8'h00, 8'h77);
    img_mounted = 1'b1;
    @(posedge clk32); #1;
    img_mounted = 1'b0;
    load_track(0, 21);
    chk("mount_ready", {31'd0, ram_ready}, 32'd1);
    track = 6'd2;
    serve_read(32'd21, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
